// File: rtl/wordlit_pkg.sv
// Shared constants, state/id types and the word-literal transform for the round-robin word arbiter.
package wordlit_pkg;

  localparam int              NREQ_DEF  = 4;
  localparam int              IN_W_DEF  = 8;
  localparam int              OUT_W_DEF = 16;
  localparam logic [OUT_W_DEF-1:0] XOR_K_DEF = 16'h0001;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} wl_state_t;

  typedef logic [$clog2(NREQ_DEF)-1:0] wl_id_t;

  // Zero-extend then XOR; no carries can occur, so the upper byte is just XOR_K's upper byte.
  function automatic logic [OUT_W_DEF-1:0] wl_xform(input logic [IN_W_DEF-1:0] word);
    return {{(OUT_W_DEF-IN_W_DEF){1'b0}}, word} ^ XOR_K_DEF;
  endfunction

endpackage

// File: rtl/wordlit_rr_arbiter_rr_pick.sv
// Rotate-priority picker: first asserted request at or after rr_ptr, modulo NREQ.
// Purely combinational; no backpressure of its own.
module wordlit_rr_arbiter_rr_pick
  import wordlit_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_idx
);

  logic [ID_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit wins; ID_W-bit add wraps mod NREQ.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = rr_ptr + ID_W'(k);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/wordlit_rr_arbiter.sv
// Round-robin share of one zero-extend/XOR datapath among NREQ requesters, result tagged with id.
// Latency 1 cycle; stalls all requesters while the output register is full and not drained.
module wordlit_rr_arbiter
  import wordlit_pkg::*;
#(
  parameter int               NREQ  = NREQ_DEF,
  parameter int               IN_W  = IN_W_DEF,
  parameter int               OUT_W = OUT_W_DEF,
  parameter logic [OUT_W-1:0] XOR_K = XOR_K_DEF,
  parameter int               ID_W  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_data,
  output logic [ID_W-1:0]      out_id,
  input  logic                 out_ready,
  output logic                 busy
);

  wl_state_t       state;
  logic [ID_W-1:0] rr_ptr;
  logic            grant_valid;
  logic [ID_W-1:0] grant_idx;
  logic            slot_free;
  logic            grant;
  logic [IN_W-1:0] word;
  logic [OUT_W-1:0] result;

  wordlit_rr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req         (req_valid),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign out_valid = (state == FULL);
  assign slot_free = (state == EMPTY) | (out_ready & out_valid);
  // rst gates the grant so no handshake can complete while reset is held.
  assign grant     = slot_free & grant_valid & ~rst;
  assign req_ready = grant ? (NREQ'(1) << grant_idx) : '0;
  assign busy      = out_valid | (|req_valid);

  always_comb begin
    word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        word = req_data[i*IN_W +: IN_W];
      end
    end
  end

  assign result = {{(OUT_W-IN_W){1'b0}}, word} ^ XOR_K;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_id   <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      state    <= FULL;
      out_data <= result;
      out_id   <= grant_idx;
      rr_ptr   <= grant_idx + ID_W'(1);
    end else if (out_valid && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: doc/wordlit_rr_arbiter.md
Name: wordlit_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one word-literal XOR datapath among NREQ requesters. Each requester presents an 8-bit word over a valid/ready handshake. The datapath computes zero_extend16(word) ^ XOR_K. The result is registered and returned on a single valid/ready output channel, tagged with the requester id. The block sits between the requester front-ends and the downstream consumer of 16-bit results.

Parameters:
NREQ, 4, number of requesters (power of two, 2..16)
IN_W, 8, requester word width
OUT_W, 16, result width (OUT_W > IN_W)
XOR_K, 16'h0001, constant XORed into the zero-extended word
ID_W, $clog2(NREQ), width of the requester id tag

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  per-requester word valid
req_data  input  NREQ*IN_W  packed words; requester i occupies bits [i*IN_W +: IN_W]
req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
out_valid  output  1  result valid
out_data  output  OUT_W  result = {zeros, word} ^ XOR_K
out_id  output  ID_W  index of the requester that produced out_data
out_ready  input  1  downstream accept
busy  output  1  high when out_valid is high or any req_valid is high

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). On assertion the block forces immediately: out_valid=0, out_data=0, out_id=0, rr_ptr=0, state=EMPTY. req_ready=0 while rst is high.
- Output register FSM:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- slot_free = (state==EMPTY) | (out_ready & out_valid).
- Grant, combinational:
  - Grant only when slot_free and |req_valid.
  - Select the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 for the granted index g only. All other bits are 0.
  - req_ready never asserts for a requester whose req_valid is low.
- On a grant at a clock edge:
  - out_data <= zero_ext(req_data[g]) ^ XOR_K.
  - out_id <= g.
  - state <= FULL.
  - rr_ptr <= (g+1) mod NREQ. Wraps from NREQ-1 to 0.
- Latency: request accepted in cycle n gives out_valid in cycle n+1.
- Throughput: one result per cycle while out_ready stays high.
- Drain without a new grant: out_ready & out_valid with no req_valid gives state <= EMPTY. out_data and out_id keep their last values.
- Simultaneous drain and grant: state stays FULL and the new result replaces the old one in the same edge. No bubble.
- Stall: FULL with out_ready=0 holds out_data, out_id and out_valid stable. All req_ready stay 0. rr_ptr does not change.
- Fairness: a continuously valid requester is granted within NREQ grants. rr_ptr advances only on a grant.
- Arithmetic: the word is zero-extended to OUT_W before the XOR. No sign extension, no carries.
- Reset mid-operation discards any pending result. No requester handshake completes in a cycle where rst is high.
- req_data may change while req_valid is low. While valid and not yet granted, requesters hold req_data stable (standard valid/ready rule); the bench checks this.

Decomposition:
- Package wordlit_pkg holds:
  - constants NREQ_DEF, IN_W_DEF, OUT_W_DEF, XOR_K_DEF;
  - typedef enum logic {EMPTY, FULL} wl_state_t;
  - typedef for the id tag;
  - function wl_xform(word) returning zero_ext(word) ^ XOR_K, shared with the scoreboard.
- One sub-module, rr_pick: combinational rotate-priority picker. Inputs are the request vector and rr_ptr. Outputs are grant_valid and a grant index. It is parameterised by NREQ. The top holds the FSM, rr_ptr and the output register.

Test Plan:
- Single request: req_valid=4'b0100, data 8'h05, out_ready=1 -> req_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=16'h0004, out_id=2.
- Rotation: all four valid with data 8'h10..8'h13, out_ready=1 -> out_id sequence 0,1,2,3,0; out_data 16'h0011, 16'h0010, 16'h0013, 16'h0012, one per cycle.
- Backpressure: FULL with out_ready=0 for 5 cycles -> out_data/out_id stable and req_ready=0 throughout; after out_ready=1, same-cycle regrant with no bubble cycle.
- Wrap and fairness: rr_ptr=3 with req_valid=4'b1001 -> grant 3, then grant 0; requester 0 held valid waits at most 3 grants.
- Width edges: data 8'hFF -> 16'h00FE; 8'h01 -> 16'h0000; 8'h00 -> 16'h0001.
- Reset mid-stall: FULL with out_ready=0, pulse rst asynchronously between edges -> out_valid=0, out_data=0 and req_ready=0 immediately; after release first grant starts at requester 0.
